rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Parametrised successor to the team's 2:1 single-bit mux: an N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes and a built-in arbiter (round-robin or fixed-priority, run-time selectable). It sits between several producer blocks and one shared consumer. It chooses one requesting channel per cycle, captures that channel's word into an output register, and reports which channel supplied the word.

## Interface
- WIDTH, 8, data width per channel (≥1)
- N, 4, channel count (≥2)
- SEL_W, $clog2(N), width of the channel index (derived, do not override)

- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i has a word
- in_ready  output  N  channel i's word is accepted this cycle
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- out_data  output  WIDTH  registered selected word
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  consumer accepts the word this cycle
- grant_any  output  1  combinational: some channel is accepted this cycle

## Operation
- One clock domain. Reset is synchronous and active-high.
- load_en = ~out_valid | out_ready. The output register is empty or is being drained this cycle.
- Arbitration is combinational over in_valid and is evaluated every cycle.
  - mode=1: grant the lowest-index channel with in_valid=1.
  - mode=0: grant the first channel with in_valid=1, searching upward from ptr+1 modulo N.
- in_ready[i] = grant[i] & load_en. At most one bit is set (one-hot or zero). in_ready never depends on in_valid of the same channel beyond the grant.
- Transfer on channel i happens when in_valid[i] & in_ready[i]. On the next edge:
  - out_data ← channel i word
  - out_sel ← i
  - out_valid ← 1
- If load_en=1 and no in_valid bit is set, out_valid ← 0 on the next edge.
- If out_valid=1 and out_ready=0, the output register is held: out_data, out_sel and out_valid are all unchanged.
- Round-robin pointer ptr (SEL_W bits):
  - ptr ← i only on a transfer.
  - ptr is updated in both modes, so that switching back to mode 0 resumes fairly.
- A mode change takes effect on the same cycle's arbitration. No flush, no lost word.
- Producers must hold in_data/in_valid stable until accepted. The block does not check this.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, ptr=N-1 (so channel 0 has first round-robin priority)
  - in_ready=0 during reset and on the cycle after it when no in_valid is set
- Latency: a word accepted in cycle t appears at out_data with out_valid=1 in cycle t+1.
- Throughput: one word per cycle sustained, provided out_ready=1.
- Simultaneous drain + load: out_valid stays 1 and the register is overwritten with the new word. There is no bubble.
- Back-pressure: with out_valid=1 and out_ready=0, all in_ready=0 and ptr is frozen.
- Round-robin wrap: with ptr=N-1, the search order is 0,1,…,N-1. With ptr=k, the order is k+1,…,N-1,0,…,k.
- Single requester: that channel is granted every cycle regardless of ptr.
- Reset asserted mid-transfer: the reset values win on that edge and the in-flight word is discarded. Producers see in_ready=0 and must retry.
- No combinational path from out_ready to out_data. in_ready depends combinationally on out_ready, in_valid and mode.

## Test plan
1. **Reset and idle.** Hold rst for 2 cycles, then all in_valid=0.
   - Expect out_valid=0, out_data=0, out_sel=0 and in_ready=0 throughout.
2. **Round-robin fairness.** N=4, mode=0, in_valid=4'b1111 held, out_ready=1, channels carrying 8'hA0..8'hA3.
   - Expect out_sel sequence 0,1,2,3,0,… with out_data A0,A1,A2,A3,A0.
   - Expect one word per cycle from the 2nd cycle on.
3. **Fixed priority.** mode=1, in_valid=4'b1010.
   - Expect channel 1 granted every cycle; channel 3 is never granted until in_valid[1]=0.
   - Then drop in_valid[1]: expect channel 3 granted the next cycle.
4. **Back-pressure.** Deassert out_ready for 3 cycles while out_valid=1 with out_data=8'h5C, out_sel=2.
   - Expect out_data/out_sel/out_valid unchanged, all in_ready=0 and ptr frozen.
   - Re-assert out_ready: expect the next grant to be channel 3 (search resumes from ptr+1=3).
5. **Mode switch and wrap.** In mode 0, transfer from channel 3 (ptr=3), then mode=1 for one transfer (from channel 0), then mode=0 with in_valid=4'b0110.
   - Expect channel 1 to be granted next.
6. **Reset mid-stream.** Assert rst while out_valid=1 and a transfer is occurring.
   - Expect out_valid=0 and ptr=N-1 on the next edge.
   - After release with in_valid=4'b1001 in mode 0, expect the first grant to go to channel 0.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter_if
// Bus bundle between N producer channels, the arbitrating mux, and the single
// shared consumer.
//
// Signals:
//   in_data   [N*WIDTH]  channel i word at [i*WIDTH +: WIDTH]
//   in_valid  [N]        channel i offers a word
//   in_ready  [N]        channel i word accepted this cycle (one-hot or zero)
//   mode      [1]        0 = round-robin, 1 = fixed priority (lowest index wins)
//   out_data  [WIDTH]    registered selected word
//   out_sel   [SEL_W]    channel that supplied out_data
//   out_valid [1]        out_data/out_sel hold a word
//   out_ready [1]        consumer accepts the word this cycle
//   grant_any [1]        some channel is accepted this cycle
//
// Modports:
//   master  driven by the producers/consumer side (or a testbench)
//   slave   used by rr_mux_arbiter
// -----------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;
    logic               grant_any;

    modport master (
        output in_data, in_valid, mode, out_ready,
        input  in_ready, out_data, out_sel, out_valid, grant_any
    );

    modport slave (
        input  in_data, in_valid, mode, out_ready,
        output in_ready, out_data, out_sel, out_valid, grant_any
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
// N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on
// both sides and a built-in arbiter (round-robin or fixed priority, selected
// at run time by bus.mode). One channel is accepted per cycle; its word and
// index are captured into a single output register.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   rr_mux_arbiter_if.slave (see interface file for signal list)
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  bus
);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;      // last channel that transferred

    logic [WIDTH-1:0] w_word [N];
    logic             w_load_en;
    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic             w_accept;

    // Output register is empty or being drained this cycle.
    assign w_load_en = ~r_out_valid | bus.out_ready;

    // Grant qualified by load_en; reset forces every in_ready low so no
    // producer believes its word was taken while state is being cleared.
    assign w_accept  = w_found & w_load_en & ~rst;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign w_word[gi]       = bus.in_data[gi*WIDTH +: WIDTH];
            assign bus.in_ready[gi] = w_accept && (w_idx == SEL_W'(gi));
        end
    endgenerate

    // Arbitration. Both searches walk their order backwards so the last hit
    // written is the highest-priority requester.
    always_comb begin : p_arb
        logic [SEL_W-1:0] j;
        w_found = 1'b0;
        w_idx   = '0;
        j       = '0;
        if (bus.mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                j = SEL_W'(i);
                if (bus.in_valid[j]) begin
                    w_found = 1'b1;
                    w_idx   = j;
                end
            end
        end else begin
            // Search order ptr+1, ptr+2, ..., ptr (mod N).
            for (int k = N; k >= 1; k--) begin
                j = SEL_W'((int'(r_ptr) + k) % N);
                if (bus.in_valid[j]) begin
                    w_found = 1'b1;
                    w_idx   = j;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= SEL_W'(N - 1);  // channel 0 first after reset
        end else if (w_load_en) begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word[w_idx];
                r_out_sel   <= w_idx;
                // Tracked in both modes so returning to round-robin stays fair.
                r_ptr       <= w_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.grant_any = w_accept;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Table-driven bench for rr_mux_arbiter (N=4, WIDTH=8). Each table row gives
// the inputs for one cycle and the expected in_ready / out_valid. Words that
// the table says will be accepted are pushed to a scoreboard queue and are
// compared against out_data/out_sel while the DUT presents them; they are
// popped when the consumer takes them.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter;
    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int NV    = 30;

    localparam logic [31:0] D0 = 32'hA3A2A1A0;
    localparam logic [31:0] D1 = 32'hA35CA1A0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

    rr_mux_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        mode;
        logic [3:0]  valid;
        logic        ready;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic        zero;     // output register must read all-zero
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
    } sb_t;

    vec_t vecs [NV];
    sb_t  sb_q [$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int vi,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h want %h", name, vi, act, exp);
        end
    endtask

    initial begin
        //          rst   mode  valid  rdy   data exp_rdy ov    zero
        // reset and idle (valid during reset must still be refused)
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b1, D0, 4'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 4'hF, 1'b1, D0, 4'h0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, D0, 4'h0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, D0, 4'h0, 1'b0, 1'b1};
        // round-robin fairness, all four requesting
        vecs[4]  = '{1'b0, 1'b0, 4'hF, 1'b1, D0, 4'b0001, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'hF, 1'b1, D0, 4'b0010, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'hF, 1'b1, D0, 4'b0100, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'hF, 1'b1, D0, 4'b1000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'hF, 1'b1, D0, 4'b0001, 1'b1, 1'b0};
        // fixed priority: 1 beats 3 until 1 drops
        vecs[9]  = '{1'b0, 1'b1, 4'hA, 1'b1, D0, 4'b0010, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'hA, 1'b1, D0, 4'b0010, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'hA, 1'b1, D0, 4'b0010, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 4'h8, 1'b1, D0, 4'b1000, 1'b1, 1'b0};
        // load 5C from channel 2, then back-pressure 3 cycles
        vecs[13] = '{1'b0, 1'b1, 4'h4, 1'b1, D1, 4'b0100, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'hF, 1'b0, D1, 4'b0000, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'hF, 1'b0, D1, 4'b0000, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 4'hF, 1'b0, D1, 4'b0000, 1'b1, 1'b0};
        // release: search resumes at ptr+1 = 3
        vecs[17] = '{1'b0, 1'b0, 4'hF, 1'b1, D1, 4'b1000, 1'b1, 1'b0};
        // mode switch: fixed picks 0, then round-robin from 1
        vecs[18] = '{1'b0, 1'b1, 4'hF, 1'b1, D1, 4'b0001, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 4'h6, 1'b1, D1, 4'b0010, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 4'h6, 1'b1, D1, 4'b0100, 1'b1, 1'b0};
        // reset while holding a word; word discarded, ptr back to N-1
        vecs[21] = '{1'b1, 1'b0, 4'hF, 1'b0, D1, 4'b0000, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 4'h9, 1'b1, D1, 4'b0001, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 4'h9, 1'b1, D1, 4'b1000, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 4'h9, 1'b1, D1, 4'b0001, 1'b1, 1'b0};
        // drain to empty, then load into empty register with out_ready=0
        vecs[25] = '{1'b0, 1'b0, 4'h0, 1'b1, D1, 4'b0000, 1'b1, 1'b0};
        vecs[26] = '{1'b0, 1'b0, 4'h0, 1'b1, D1, 4'b0000, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 1'b0, 4'h4, 1'b0, D1, 4'b0100, 1'b0, 1'b0};
        vecs[28] = '{1'b0, 1'b0, 4'h0, 1'b0, D1, 4'b0000, 1'b1, 1'b0};
        vecs[29] = '{1'b0, 1'b0, 4'h0, 1'b1, D1, 4'b0000, 1'b1, 1'b0};

        rst           = 1'b1;
        bus.mode      = 1'b0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        bus.in_data   = '0;

        for (int i = 0; i < NV; i++) begin
            vec_t v;
            sb_t  e;
            v = vecs[i];
            @(negedge clk);
            rst           = v.rst;
            bus.mode      = v.mode;
            bus.in_valid  = v.valid;
            bus.out_ready = v.ready;
            bus.in_data   = v.data;
            #2;
            n_vec++;
            $display("vec %0d: rst=%b mode=%b valid=%b rdy_in=%b -> in_ready=%b ov=%b data=%h sel=%0d",
                     i, v.rst, v.mode, v.valid, v.ready, bus.in_ready,
                     bus.out_valid, bus.out_data, bus.out_sel);

            chk("in_ready",  i, 32'(bus.in_ready),  32'(v.exp_rdy));
            chk("grant_any", i, 32'(bus.grant_any), 32'(|v.exp_rdy));
            chk("out_valid", i, 32'(bus.out_valid), 32'(v.exp_ov));
            if (v.zero) begin
                chk("out_data_rst", i, 32'(bus.out_data), 32'h0);
                chk("out_sel_rst",  i, 32'(bus.out_sel),  32'h0);
            end
            if (v.exp_ov) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_empty vec %0d: got no expected word want one", i);
                end else begin
                    e = sb_q[0];
                    chk("out_data", i, 32'(bus.out_data), 32'(e.data));
                    chk("out_sel",  i, 32'(bus.out_sel),  32'(e.sel));
                    if (v.ready) void'(sb_q.pop_front());
                end
            end

            if (v.rst) begin
                sb_q.delete();
            end else if (v.exp_rdy != 4'h0) begin
                for (int k = 0; k < N; k++) begin
                    if (v.exp_rdy[k]) begin
                        e.data = v.data[k*WIDTH +: WIDTH];
                        e.sel  = 2'(k);
                    end
                end
                sb_q.push_back(e);
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
